// File: rtl/lcd_pkg.sv
// Shared LCD definitions: arbiter FSM states, HD44780 command bytes that
// need the long execution gap, and 50 MHz timing defaults also used by the
// init sequencer.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_GAP   = 2'd2
    } lcdArbState_t;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

    localparam int LCD_CLOCK_HZ     = 50_000_000;
    localparam int LCD_GAP_CYCLES   = 2000;
    localparam int LCD_CLEAR_CYCLES = 82000;

    // Clear and home are the only commands the controller needs 1.64 ms for,
    // and only when sent as commands (RS=0); the same codes as data are
    // ordinary characters.
    function automatic logic isLongCmd(input logic rs, input logic [7:0] data);
        return (!rs) && ((data == LCD_CMD_CLEAR) || (data == LCD_CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_rr_pick.sv
// Round-robin picker: returns the first requester at or after the pointer,
// wrapping around, as a one-hot vector plus a valid flag. Purely combinational.
module lcd_rr_pick
    import lcd_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] reqVec,
    input  logic [IDX_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] grantOneHot,
    output logic               grantValid
);

    // Walk the clients starting at the pointer and keep the first one asking.
    always_comb begin
        int k;
        k           = 0;
        grantOneHot = '0;
        grantValid  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(pointer) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (!grantValid && reqVec[k]) begin
                grantOneHot[k] = 1'b1;
                grantValid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter sharing one LCD byte writer among NUM_REQ clients.
// Forwards one {RS, byte} at a time, acknowledges it when the sender reports
// completion, then holds off the next write for the HD44780 execution time.
// Optional macro LCD_ARB_LOCK_EN adds iLock, letting a client keep the
// writer across several bytes so multi-byte sequences stay atomic.
module lcd_write_arbiter
    import lcd_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int GAP_CYCLES   = LCD_GAP_CYCLES,
    parameter int CLEAR_CYCLES = LCD_CLEAR_CYCLES
)(
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [NUM_REQ-1:0]     iReq,
    input  logic [NUM_REQ-1:0]     iRS,
    input  logic [8*NUM_REQ-1:0]   iData,
`ifdef LCD_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]     iLock,
`endif
    output logic [NUM_REQ-1:0]     oAck,
    output logic [NUM_REQ-1:0]     oGrant,
    output logic                   oBusy,
    output logic                   oWriteBegin,
    output logic                   oRS,
    output logic [7:0]             oData,
    input  logic                   iWriteDone
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(CLEAR_CYCLES + 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES);
    localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_REQ - 1);

    lcdArbState_t     state, stateNext;
    logic [IW-1:0]    pointer, pointerNext;
    logic [IW-1:0]    gIdx, gIdxNext;
    logic [CW-1:0]    counter, counterNext;
    logic [NUM_REQ-1:0] grantNext, ackNext;
    logic             writeBeginNext, rsNext, busyNext;
    logic [7:0]       dataNext;

    logic [NUM_REQ-1:0] pickGrant;
    logic             pickValid;
    logic [IW-1:0]    pickIdx;
    logic             takeValid;
    logic [IW-1:0]    takeIdx;

`ifdef LCD_ARB_LOCK_EN
    logic             reserved, reservedNext;
`endif

    lcd_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IW)
    ) rrPick (
        .reqVec      (iReq),
        .pointer     (pointer),
        .grantOneHot (pickGrant),
        .grantValid  (pickValid)
    );

    // Turn the picker's one-hot result into an index for the latches.
    always_comb begin
        pickIdx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pickGrant[i]) begin
                pickIdx = IW'(i);
            end
        end
    end

    // Decide who is served next in IDLE; a live reservation bypasses arbitration.
    always_comb begin
        takeValid = pickValid;
        takeIdx   = pickIdx;
`ifdef LCD_ARB_LOCK_EN
        if (reserved && iLock[gIdx]) begin
            takeValid = iReq[gIdx];
            takeIdx   = gIdx;
        end
`endif
    end

    // Next-state and next-output logic; every output is then registered.
    always_comb begin
        stateNext      = state;
        pointerNext    = pointer;
        gIdxNext       = gIdx;
        counterNext    = counter;
        grantNext      = oGrant;
        ackNext        = '0;
        writeBeginNext = oWriteBegin;
        rsNext         = oRS;
        dataNext       = oData;
`ifdef LCD_ARB_LOCK_EN
        reservedNext   = reserved;
`endif
        case (state)
            ST_IDLE: begin
`ifdef LCD_ARB_LOCK_EN
                if (!iLock[gIdx]) begin
                    reservedNext = 1'b0;
                end
`endif
                if (takeValid) begin
                    gIdxNext  = takeIdx;
                    rsNext    = iRS[takeIdx];
                    dataNext  = iData[takeIdx*8 +: 8];
                    grantNext = NUM_REQ'(1) << takeIdx;
                    stateNext = ST_WRITE;
                end
            end
            ST_WRITE: begin
                writeBeginNext = 1'b1;
                if (iWriteDone) begin
                    writeBeginNext = 1'b0;
                    grantNext      = '0;
                    ackNext        = NUM_REQ'(1) << gIdx;
                    pointerNext    = (gIdx == LAST_IDX) ? '0 : gIdx + IW'(1);
`ifdef LCD_ARB_LOCK_EN
                    if (reserved) begin
                        pointerNext = pointer;
                    end
`endif
                    counterNext    = isLongCmd(oRS, oData) ? CLEAR_LOAD : GAP_LOAD;
                    stateNext      = ST_GAP;
                end
            end
            ST_GAP: begin
                if (counter == '0) begin
                    stateNext = ST_IDLE;
`ifdef LCD_ARB_LOCK_EN
                    reservedNext = iLock[gIdx];
`endif
                end else begin
                    counterNext = counter - CW'(1);
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
        busyNext = (stateNext != ST_IDLE);
    end

    // State, latches, counter and outputs; synchronous reset clears everything.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= ST_IDLE;
            pointer     <= '0;
            gIdx        <= '0;
            counter     <= '0;
            oGrant      <= '0;
            oAck        <= '0;
            oWriteBegin <= 1'b0;
            oRS         <= 1'b0;
            oData       <= '0;
            oBusy       <= 1'b0;
`ifdef LCD_ARB_LOCK_EN
            reserved    <= 1'b0;
`endif
        end else begin
            state       <= stateNext;
            pointer     <= pointerNext;
            gIdx        <= gIdxNext;
            counter     <= counterNext;
            oGrant      <= grantNext;
            oAck        <= ackNext;
            oWriteBegin <= writeBeginNext;
            oRS         <= rsNext;
            oData       <= dataNext;
            oBusy       <= busyNext;
`ifdef LCD_ARB_LOCK_EN
            reserved    <= reservedNext;
`endif
        end
    end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Self-checking bench for lcd_write_arbiter. Gap lengths are scaled down
// (GAP 20, CLEAR 820) so the clear/home distinction stays visible while the
// run stays short. Lock scenario only runs when LCD_ARB_LOCK_EN is defined.
module tb_lcd_write_arbiter;

    localparam int NUM_REQ = 2;
    localparam int GAP     = 20;
    localparam int CLEAR   = 820;
    localparam int LIMIT   = 2000;

    typedef struct {
        int         client;
        logic       rs;
        logic [7:0] data;
    } wr_t;

    logic                 Clock = 1'b0;
    logic                 Reset;
    logic [NUM_REQ-1:0]   iReq;
    logic [NUM_REQ-1:0]   iRS;
    logic [8*NUM_REQ-1:0] iData;
`ifdef LCD_ARB_LOCK_EN
    logic [NUM_REQ-1:0]   iLock;
`endif
    logic [NUM_REQ-1:0]   oAck;
    logic [NUM_REQ-1:0]   oGrant;
    logic                 oBusy;
    logic                 oWriteBegin;
    logic                 oRS;
    logic [7:0]           oData;
    logic                 iWriteDone;

    wr_t        sb[$];
    int         checks = 0;
    int         errors = 0;
    int         c;
    logic [7:0] curData;
    logic       curRs;

    lcd_write_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .GAP_CYCLES   (GAP),
        .CLEAR_CYCLES (CLEAR)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .iReq        (iReq),
        .iRS         (iRS),
        .iData       (iData),
`ifdef LCD_ARB_LOCK_EN
        .iLock       (iLock),
`endif
        .oAck        (oAck),
        .oGrant      (oGrant),
        .oBusy       (oBusy),
        .oWriteBegin (oWriteBegin),
        .oRS         (oRS),
        .oData       (oData),
        .iWriteDone  (iWriteDone)
    );

    // 100 MHz-style free-running clock for the bench.
    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] check %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int cl, input logic rs, input logic [7:0] d);
        iReq[cl]         = 1'b1;
        iRS[cl]          = rs;
        iData[8*cl +: 8] = d;
    endtask

    task automatic expectWrite(input int cl, input logic rs, input logic [7:0] d);
        wr_t e;
        e.client = cl;
        e.rs     = rs;
        e.data   = d;
        sb.push_back(e);
    endtask

    // Wait for the next write to start, check its spacing, pop and compare it.
    task automatic getWrite(input string tag, input int expCycles, input int pulseAt, output int cl);
        int  cnt;
        wr_t e;
        cnt = 0;
        cl  = 0;
        while (cnt < LIMIT) begin
            @(negedge Clock);
            cnt++;
            if (pulseAt > 0 && cnt == pulseAt) begin
                iWriteDone = 1'b1;
            end
            if (pulseAt > 0 && cnt == pulseAt + 1) begin
                iWriteDone = 1'b0;
                checkOutput({tag, "_strayAck"}, 32'(oAck), 32'(0));
            end
            if (oWriteBegin) break;
        end
        if (!oWriteBegin) begin
            checkOutput({tag, "_timeout"}, 32'(oWriteBegin), 32'(1));
        end else begin
            if (expCycles > 0) begin
                checkOutput({tag, "_spacing"}, 32'(cnt), 32'(expCycles));
            end
            if (sb.size() == 0) begin
                checkOutput({tag, "_unexpected"}, 32'(oWriteBegin), 32'(0));
            end else begin
                e       = sb.pop_front();
                cl      = e.client;
                curData = e.data;
                curRs   = e.rs;
                checkOutput({tag, "_grant"}, 32'(oGrant), 32'(1) << e.client);
                checkOutput({tag, "_data"}, 32'(oData), 32'(e.data));
                checkOutput({tag, "_rs"}, 32'(oRS), 32'(e.rs));
            end
        end
    endtask

    // Act as the sender: finish after a delay, then check the ack pulse.
    task automatic completeWrite(input string tag, input int cl, input int delay);
        repeat (delay) @(negedge Clock);
        checkOutput({tag, "_held"}, 32'({oWriteBegin, oRS, oData}), 32'({1'b1, curRs, curData}));
        iWriteDone = 1'b1;
        @(negedge Clock);
        iWriteDone = 1'b0;
        checkOutput({tag, "_ack"}, 32'(oAck), 32'(1) << cl);
        checkOutput({tag, "_wbLow"}, 32'({oWriteBegin, oGrant}), 32'(0));
        checkOutput({tag, "_busyGap"}, 32'(oBusy), 32'(1));
    endtask

    task automatic waitIdle(input string tag);
        int cnt;
        cnt = 0;
        while (cnt < LIMIT && oBusy) begin
            @(negedge Clock);
            cnt++;
        end
        checkOutput({tag, "_idle"}, 32'({oBusy, oAck}), 32'(0));
    endtask

    initial begin
        Reset      = 1'b1;
        iReq       = '0;
        iRS        = '0;
        iData      = '0;
        iWriteDone = 1'b0;
`ifdef LCD_ARB_LOCK_EN
        iLock      = '0;
`endif
        repeat (3) @(negedge Clock);
        checkOutput("reset_grantAck", 32'({oGrant, oAck}), 32'(0));
        checkOutput("reset_ctrl", 32'({oBusy, oWriteBegin, oRS}), 32'(0));
        checkOutput("reset_data", 32'(oData), 32'(0));
        Reset = 1'b0;
        @(negedge Clock);

        // Single client, data byte, then a repeat held across the normal gap.
        $display("[TB] single client write");
        applyStimulus(0, 1'b1, 8'h48);
        expectWrite(0, 1'b1, 8'h48);
        expectWrite(0, 1'b1, 8'h48);
        getWrite("t1_first", 2, 0, c);
        completeWrite("t1_first", c, 10);
        getWrite("t1_repeat", GAP + 3, 0, c);
        completeWrite("t1_repeat", c, 4);
        iReq[0] = 1'b0;
        waitIdle("t1");

        // Both clients held from reset must alternate; client0 changes its byte mid-write.
        $display("[TB] round robin alternation");
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        applyStimulus(0, 1'b1, 8'h30);
        applyStimulus(1, 1'b1, 8'h31);
        expectWrite(0, 1'b1, 8'h30);
        expectWrite(1, 1'b1, 8'h31);
        expectWrite(0, 1'b1, 8'h40);
        expectWrite(1, 1'b1, 8'h31);
        getWrite("t2_w0", 2, 0, c);
        applyStimulus(0, 1'b1, 8'h40);
        completeWrite("t2_w0", c, 3);
        for (int k = 1; k < 4; k++) begin
            getWrite("t2_wn", GAP + 3, 0, c);
            completeWrite("t2_wn", c, 3);
        end
        iReq = '0;
        waitIdle("t2");

        // Gap length depends on RS and byte value.
        $display("[TB] gap length selection");
        applyStimulus(1, 1'b0, 8'h01);
        expectWrite(1, 1'b0, 8'h01);
        getWrite("t3_clear", 2, 0, c);
        completeWrite("t3_clear", c, 2);
        applyStimulus(1, 1'b0, 8'h28);
        expectWrite(1, 1'b0, 8'h28);
        getWrite("t3_afterClear", CLEAR + 3, 0, c);
        completeWrite("t3_cmd28", c, 2);
        applyStimulus(1, 1'b1, 8'h01);
        expectWrite(1, 1'b1, 8'h01);
        getWrite("t3_afterCmd", GAP + 3, 0, c);
        completeWrite("t3_data01", c, 2);
        applyStimulus(1, 1'b0, 8'h02);
        expectWrite(1, 1'b0, 8'h02);
        getWrite("t3_afterData01", GAP + 3, 0, c);
        completeWrite("t3_home", c, 2);
        applyStimulus(1, 1'b1, 8'h55);
        expectWrite(1, 1'b1, 8'h55);
        getWrite("t3_afterHome", CLEAR + 3, 0, c);
        completeWrite("t3_last", c, 2);
        iReq[1] = 1'b0;
        waitIdle("t3");

        // Reset during a write aborts it and returns the pointer to client0.
        $display("[TB] reset during write");
        applyStimulus(0, 1'b1, 8'h60);
        expectWrite(0, 1'b1, 8'h60);
        getWrite("t4_prep", 2, 0, c);
        completeWrite("t4_prep", c, 2);
        iReq[0] = 1'b0;
        waitIdle("t4_prep");
        applyStimulus(1, 1'b1, 8'h61);
        expectWrite(1, 1'b1, 8'h61);
        getWrite("t4_aborted", 2, 0, c);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        checkOutput("t4_resetWb", 32'({oWriteBegin, oAck}), 32'(0));
        checkOutput("t4_resetGrant", 32'({oBusy, oGrant}), 32'(0));
        Reset = 1'b0;
        applyStimulus(0, 1'b1, 8'h62);
        expectWrite(0, 1'b1, 8'h62);
        expectWrite(1, 1'b1, 8'h61);
        getWrite("t4_post0", 2, 0, c);
        completeWrite("t4_post0", c, 2);
        iReq[0] = 1'b0;
        getWrite("t4_post1", GAP + 3, 0, c);
        completeWrite("t4_post1", c, 2);
        iReq[1] = 1'b0;
        waitIdle("t4");

        // Stray done pulses in IDLE and GAP must not ack nor change the gap.
        $display("[TB] stray write-done pulses");
        iWriteDone = 1'b1;
        @(negedge Clock);
        iWriteDone = 1'b0;
        checkOutput("t5_idleDone", 32'({oAck, oBusy, oWriteBegin}), 32'(0));
        applyStimulus(0, 1'b1, 8'h41);
        expectWrite(0, 1'b1, 8'h41);
        expectWrite(0, 1'b1, 8'h41);
        getWrite("t5_first", 2, 0, c);
        completeWrite("t5_first", c, 2);
        getWrite("t5_gapDone", GAP + 3, 5, c);
        completeWrite("t5_second", c, 2);
        iReq[0] = 1'b0;
        waitIdle("t5");

`ifdef LCD_ARB_LOCK_EN
        // Locked client1 keeps the writer for three bytes before client0 gets it.
        $display("[TB] grant lock");
        iLock[1] = 1'b1;
        applyStimulus(1, 1'b0, 8'h80);
        expectWrite(1, 1'b0, 8'h80);
        expectWrite(1, 1'b0, 8'h80);
        expectWrite(1, 1'b0, 8'h80);
        expectWrite(0, 1'b1, 8'h11);
        getWrite("t6_lock1", 2, 0, c);
        applyStimulus(0, 1'b1, 8'h11);
        completeWrite("t6_lock1", c, 2);
        getWrite("t6_lock2", GAP + 3, 0, c);
        completeWrite("t6_lock2", c, 2);
        getWrite("t6_lock3", GAP + 3, 0, c);
        completeWrite("t6_lock3", c, 2);
        iLock[1] = 1'b0;
        iReq[1]  = 1'b0;
        getWrite("t6_client0", GAP + 3, 0, c);
        completeWrite("t6_client0", c, 2);
        iReq[0] = 1'b0;
        waitIdle("t6");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
